// File: rtl/axis_dest_demux.sv
// One-to-many AXI-Stream demultiplexer steering beats or packets by TDEST through one output register.
// Optional build macro AXIS_DEMUX_DROP_EN: discard unmatched units and count them in drop_count.
module axis_dest_demux #(
  parameter int NMASTERS    = 4,
  parameter int DATA_WIDTH  = 64,
  parameter int HAS_ID      = 0,
  parameter int HAS_LAST    = 0,
  parameter int ID_WIDTH    = 1,
  parameter int DEST_WIDTH  = 8,
  parameter int DEST_BASE   = 0,
  parameter int DEST_STRIDE = 1,
  parameter int DEST_RANGE  = 0
) (
  input  logic                           aclk,
  input  logic                           aresetn,
  input  logic                           s_valid,
  output logic                           s_ready,
  input  logic [DATA_WIDTH-1:0]          s_data,
  input  logic [DEST_WIDTH-1:0]          s_dest,
  input  logic [ID_WIDTH-1:0]            s_id,
  input  logic                           s_last,
  output logic [NMASTERS-1:0]            m_valid,
  input  logic [NMASTERS-1:0]            m_ready,
  output logic [NMASTERS*DATA_WIDTH-1:0] m_data,
  output logic [NMASTERS*DEST_WIDTH-1:0] m_dest,
  output logic [NMASTERS*ID_WIDTH-1:0]   m_id,
  output logic [NMASTERS-1:0]            m_last,
  output logic                           dest_err,
  output logic [15:0]                    drop_count
);

  localparam int IDX_W = (NMASTERS > 1) ? $clog2(NMASTERS) : 1;
  localparam int XW    = DEST_WIDTH + 5;

  typedef enum logic [1:0] {ST_IDLE, ST_PKT, ST_DROP} state_t;

  state_t                r_state;
  logic [IDX_W-1:0]      r_unit_idx;
  logic                  r_out_valid;
  logic [IDX_W-1:0]      r_out_idx;
  logic [DATA_WIDTH-1:0] r_data;
  logic [DEST_WIDTH-1:0] r_dest;
  logic [ID_WIDTH-1:0]   r_id;
  logic                  r_last;
  logic                  r_dest_err;

  logic [NMASTERS-1:0]   w_match;
  logic                  w_hit;
  logic [IDX_W-1:0]      w_dec_idx;
  logic [XW-1:0]         w_dest_x;
  logic                  w_first;
  logic                  w_drop;
  logic [IDX_W-1:0]      w_tgt;
  logic                  w_acc;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_unit_end;
  logic                  w_last_in;
  logic                  w_unmatched_acc;

  assign w_dest_x = XW'(s_dest);

  // Lower bound tested through the borrow of a widened subtract so no compare folds to a constant.
  generate
    for (genvar gi = 0; gi < NMASTERS; gi++) begin : g_dec
      localparam logic [XW-1:0] LO = XW'(DEST_BASE + gi * DEST_STRIDE);
      localparam logic [XW-1:0] HI = LO + XW'(DEST_RANGE);
      logic [XW:0] w_diff;
      assign w_diff       = {1'b0, w_dest_x} - {1'b0, LO};
      assign w_match[gi]  = !w_diff[XW] && (w_dest_x <= HI);
    end
  endgenerate

  always_comb begin
    w_hit     = 1'b0;
    w_dec_idx = '0;
    for (int i = NMASTERS - 1; i >= 0; i--) begin
      if (w_match[i]) begin
        w_hit     = 1'b1;
        w_dec_idx = IDX_W'(i);
      end
    end
  end

  assign w_first = (r_state == ST_IDLE);

`ifdef AXIS_DEMUX_DROP_EN
  assign w_drop = (r_state == ST_DROP) || (w_first && !w_hit);
`else
  assign w_drop = 1'b0;
`endif

  assign w_tgt           = w_first ? (w_hit ? w_dec_idx : '0) : r_unit_idx;
  assign w_pop           = r_out_valid && m_ready[r_out_idx];
  assign s_ready         = w_drop || !r_out_valid || m_ready[r_out_idx];
  assign w_acc           = s_valid && s_ready;
  assign w_push          = w_acc && !w_drop;
  assign w_unit_end      = (HAS_LAST != 0) ? s_last : 1'b1;
  assign w_last_in       = (HAS_LAST != 0) && s_last;
  assign w_unmatched_acc = w_acc && w_first && !w_hit;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state    <= ST_IDLE;
      r_unit_idx <= '0;
    end else if (w_acc) begin
      case (r_state)
        ST_IDLE: begin
          if (!w_unit_end) begin
            r_unit_idx <= w_tgt;
            r_state    <= w_drop ? ST_DROP : ST_PKT;
          end
        end
        ST_PKT, ST_DROP: begin
          if (w_unit_end) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Push takes priority over pop so a simultaneous pop and push reloads without a bubble.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_out_valid <= 1'b0;
      r_out_idx   <= '0;
      r_data      <= '0;
      r_dest      <= '0;
      r_id        <= '0;
      r_last      <= 1'b0;
      r_dest_err  <= 1'b0;
    end else begin
      r_dest_err <= w_unmatched_acc;
      if (w_push) begin
        r_out_valid <= 1'b1;
        r_out_idx   <= w_tgt;
        r_data      <= s_data;
        r_dest      <= s_dest;
        r_id        <= s_id;
        r_last      <= w_last_in;
      end else if (w_pop) begin
        r_out_valid <= 1'b0;
      end
    end
  end

`ifdef AXIS_DEMUX_DROP_EN
  logic [15:0] r_drop_count;
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_drop_count <= '0;
    end else if (w_unmatched_acc && (r_drop_count != 16'hFFFF)) begin
      r_drop_count <= r_drop_count + 16'd1;
    end
  end
  assign drop_count = r_drop_count;
`else
  assign drop_count = 16'd0;
`endif

  assign dest_err = r_dest_err;

  generate
    for (genvar gi = 0; gi < NMASTERS; gi++) begin : g_out
      assign m_valid[gi] = r_out_valid && (r_out_idx == IDX_W'(gi));
      assign m_last[gi]  = r_last && (r_out_idx == IDX_W'(gi));
      assign m_data[gi*DATA_WIDTH +: DATA_WIDTH] = r_data;
      assign m_dest[gi*DEST_WIDTH +: DEST_WIDTH] = r_dest;
      assign m_id[gi*ID_WIDTH +: ID_WIDTH]       = (HAS_ID != 0) ? r_id : '0;
    end
  endgenerate

endmodule

// File: tb/tb_axis_dest_demux.sv
// Bench for axis_dest_demux: directed steps plus randomized packets against a queue-based routing model.
// Expectations follow AXIS_DEMUX_DROP_EN when it is defined for the build.
module tb_axis_dest_demux;

  localparam int NM  = 4;
  localparam int DW  = 64;
  localparam int DSW = 8;
  localparam int IW  = 4;

`ifdef AXIS_DEMUX_DROP_EN
  localparam bit DROP_EN = 1'b1;
`else
  localparam bit DROP_EN = 1'b0;
`endif

  logic              aclk;
  logic              aresetn;
  logic              s_valid;
  logic              s_ready;
  logic [DW-1:0]     s_data;
  logic [DSW-1:0]    s_dest;
  logic [IW-1:0]     s_id;
  logic              s_last;
  logic [NM-1:0]     m_valid;
  logic [NM-1:0]     m_ready;
  logic [NM*DW-1:0]  m_data;
  logic [NM*DSW-1:0] m_dest;
  logic [NM*IW-1:0]  m_id;
  logic [NM-1:0]     m_last;
  logic              dest_err;
  logic [15:0]       drop_count;

  axis_dest_demux #(
    .NMASTERS(NM), .DATA_WIDTH(DW), .HAS_ID(1), .HAS_LAST(1), .ID_WIDTH(IW),
    .DEST_WIDTH(DSW), .DEST_BASE('h10), .DEST_STRIDE(4), .DEST_RANGE(1)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_dest(s_dest),
    .s_id(s_id), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_dest(m_dest),
    .m_id(m_id), .m_last(m_last),
    .dest_err(dest_err), .drop_count(drop_count)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct {
    int             idx;
    logic [DW-1:0]  data;
    logic [DSW-1:0] dest;
    logic [IW-1:0]  id;
    logic           last;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  bit   mdl_in_unit = 0;
  bit   mdl_drop = 0;
  int   mdl_idx = 0;
  int   exp_err = 0;
  int   seen_err = 0;
  int   exp_drops = 0;
  bit   rnd_ready = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Master i owns dests 0x10+4i and 0x11+4i; anything else is unmatched.
  function automatic int decode(input logic [DSW-1:0] d);
    for (int i = 0; i < NM; i++) begin
      if (int'(d) >= 16 + 4 * i && int'(d) <= 17 + 4 * i) return i;
    end
    return -1;
  endfunction

  task automatic model_accept(input logic [DSW-1:0] d, input logic l,
                              input logic [DW-1:0] data, input logic [IW-1:0] id);
    exp_t e;
    int   idx;
    if (!mdl_in_unit) begin
      idx = decode(d);
      mdl_drop = 1'b0;
      if (idx < 0) begin
        exp_err++;
        idx = 0;
        if (DROP_EN) begin
          mdl_drop = 1'b1;
          if (exp_drops < 65535) exp_drops++;
        end
      end
      mdl_idx = idx;
      if (!l) mdl_in_unit = 1'b1;
    end else if (l) begin
      mdl_in_unit = 1'b0;
    end
    if (!mdl_drop) begin
      e.idx = mdl_idx; e.data = data; e.dest = d; e.id = id; e.last = l;
      q.push_back(e);
    end
  endtask

  // Monitor on the falling edge: stability, one-hot, delivery order and content, accepts, error pulses.
  initial begin
    logic [311:0] prev_all;
    bit           prev_stall;
    exp_t         e;
    prev_all   = '0;
    prev_stall = 1'b0;
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        q.delete();
        mdl_in_unit = 1'b0;
        mdl_drop    = 1'b0;
        exp_drops   = 0;
        prev_stall  = 1'b0;
      end else begin
        chk("onehot", 64'($onehot0(m_valid)), 64'd1);
        if (prev_stall)
          chk("stable", 64'({m_valid, m_data, m_dest, m_id, m_last} == prev_all), 64'd1);
        prev_all   = {m_valid, m_data, m_dest, m_id, m_last};
        prev_stall = |(m_valid & ~m_ready);
        for (int i = 0; i < NM; i++) begin
          if (m_valid[i] && m_ready[i]) begin
            if (q.size() == 0) begin
              chk("unexpected_beat", 64'(i), 64'hFFFF);
            end else begin
              e = q.pop_front();
              chk("out_idx", 64'(i), 64'(e.idx));
              chk("out_data", m_data[i*DW +: DW], e.data);
              chk("out_dest", 64'(m_dest[i*DSW +: DSW]), 64'(e.dest));
              chk("out_id", 64'(m_id[i*IW +: IW]), 64'(e.id));
              chk("out_last", 64'(m_last[i]), 64'(e.last));
              for (int j = 0; j < NM; j++)
                chk("slice_same", m_data[j*DW +: DW], e.data);
            end
          end
        end
        if (s_valid && s_ready) model_accept(s_dest, s_last, s_data, s_id);
        if (dest_err) seen_err++;
      end
    end
  end

  task automatic tick();
    @(posedge aclk);
    #1;
    if (rnd_ready) begin
      for (int i = 0; i < NM; i++) m_ready[i] = ($urandom_range(3) != 0);
    end
  endtask

  task automatic drive(input logic [DSW-1:0] d, input logic l, input logic [DW-1:0] data);
    s_valid = 1'b1;
    s_dest  = d;
    s_last  = l;
    s_data  = data;
    s_id    = IW'($urandom);
  endtask

  // Hold a beat until accepted, with a bounded wait.
  task automatic send(input logic [DSW-1:0] d, input logic l);
    int n;
    drive(d, l, {$urandom, $urandom});
    #1;
    n = 0;
    while (!s_ready && n < 60) begin
      tick();
      #1;
      n++;
    end
    if (!s_ready) begin
      chk("send_timeout", 64'(n), 64'd0);
      s_valid = 1'b0;
    end else begin
      tick();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DSW-1:0] t1_dest [4];
    logic [NM-1:0]  t1_exp [4];
    logic [DW-1:0]  d1;
    logic [DW-1:0]  d2;
    int             err0;
    int             len;
    logic [DSW-1:0] dd;

    aresetn = 1'b0;
    s_valid = 1'b0; s_data = '0; s_dest = '0; s_id = '0; s_last = 1'b0;
    m_ready = '1;
    repeat (3) @(posedge aclk);
    #1;
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    aresetn = 1'b1;
    #1;
    chk("rst_s_ready", 64'(s_ready), 64'd1);
    chk("rst_m_data", m_data[63:0], 64'd0);
    chk("rst_m_dest", 64'(m_dest), 64'd0);
    chk("rst_m_id", 64'(m_id), 64'd0);
    chk("rst_m_last", 64'(m_last), 64'd0);
    chk("rst_dest_err", 64'(dest_err), 64'd0);
    chk("rst_drop_count", 64'(drop_count), 64'd0);
    tick();

    // Back-to-back single-beat units, one per cycle.
    t1_dest = '{8'h10, 8'h15, 8'h1C, 8'h1D};
    t1_exp  = '{4'b0001, 4'b0010, 4'b1000, 4'b1000};
    for (int k = 0; k < 4; k++) begin
      drive(t1_dest[k], 1'b1, 64'hA000 + 64'(k));
      #1;
      chk("t1_s_ready", 64'(s_ready), 64'd1);
      tick();
      chk("t1_m_valid", 64'(m_valid), 64'(t1_exp[k]));
      chk("t1_m_data", m_data[0 +: DW], 64'hA000 + 64'(k));
    end
    s_valid = 1'b0;
    tick();
    chk("t1_drain", 64'(m_valid), 64'd0);

    // Packet locked to master 1 whatever the later dests say.
    drive(8'h14, 1'b0, 64'hB0); tick();
    chk("t2_b0_valid", 64'(m_valid), 64'b0010);
    chk("t2_b0_last", 64'(m_last), 64'd0);
    drive(8'h10, 1'b0, 64'hB1); tick();
    chk("t2_b1_valid", 64'(m_valid), 64'b0010);
    chk("t2_b1_last", 64'(m_last), 64'd0);
    drive(8'h10, 1'b1, 64'hB2); tick();
    chk("t2_b2_valid", 64'(m_valid), 64'b0010);
    chk("t2_b2_last", 64'(m_last), 64'b0010);
    s_valid = 1'b0;
    tick();

    // Stalled master 2 blocks the next beat for 5 cycles.
    d1 = 64'hDEAD_BEEF_0000_0002;
    d2 = 64'hC0FF_EE00_0000_0000;
    m_ready = 4'b1011;
    drive(8'h18, 1'b1, d1); tick();
    chk("t3_valid", 64'(m_valid), 64'b0100);
    drive(8'h10, 1'b1, d2);
    #1;
    for (int k = 0; k < 5; k++) begin
      chk("t3_s_ready", 64'(s_ready), 64'd0);
      chk("t3_hold_valid", 64'(m_valid), 64'b0100);
      chk("t3_hold_data", m_data[2*DW +: DW], d1);
      chk("t3_hold_dest", 64'(m_dest[2*DSW +: DSW]), 64'h18);
      tick();
      #1;
    end
    m_ready = 4'b1111;
    #1;
    chk("t3_release_s_ready", 64'(s_ready), 64'd1);
    tick();
    chk("t3_next_valid", 64'(m_valid), 64'b0001);
    chk("t3_next_data", m_data[0 +: DW], d2);
    s_valid = 1'b0;
    tick();
    tick();

    // Unmatched 4-beat packet, then a packet to master 0.
    err0 = seen_err;
    for (int k = 0; k < 4; k++) begin
      drive(8'h30, (k == 3), 64'hE0 + 64'(k));
      #1;
      chk("t4_s_ready", 64'(s_ready), 64'd1);
      tick();
      chk("t4_m_valid", 64'(m_valid), DROP_EN ? 64'd0 : 64'b0001);
    end
    s_valid = 1'b0;
    tick();
    tick();
    chk("t4_dest_err_pulses", 64'(seen_err - err0), 64'd1);
    chk("t4_drop_count", 64'(drop_count), DROP_EN ? 64'd1 : 64'd0);
    drive(8'h10, 1'b0, 64'hF0); tick();
    chk("t4_next_b0", 64'(m_valid), 64'b0001);
    drive(8'h33, 1'b1, 64'hF1); tick();
    chk("t4_next_b1", 64'(m_valid), 64'b0001);
    s_valid = 1'b0;
    tick();

    // Randomized packets with random back-pressure.
    rnd_ready = 1'b1;
    for (int u = 0; u < 150; u++) begin
      len = $urandom_range(1, 4);
      for (int b = 0; b < len; b++) begin
        if ($urandom_range(4) == 0) dd = 8'($urandom_range(8'h23, 8'hFF));
        else dd = 8'($urandom_range(8'h0C, 8'h22));
        send(dd, (b == len - 1));
        if ($urandom_range(3) == 0) begin
          s_valid = 1'b0;
          tick();
        end
      end
    end
    s_valid = 1'b0;
    rnd_ready = 1'b0;
    m_ready = '1;
    repeat (3) tick();
    chk("rand_drained", 64'(q.size()), 64'd0);
    chk("rand_dest_err", 64'(seen_err), 64'(exp_err));
    chk("rand_drop_count", 64'(drop_count), DROP_EN ? 64'(exp_drops) : 64'd0);

    // Reset in the middle of beat 2 of a packet.
    drive(8'h14, 1'b0, 64'h70); tick();
    drive(8'h14, 1'b0, 64'h71); tick();
    drive(8'h10, 1'b0, 64'h72);
    #2;
    aresetn = 1'b0;
    #1;
    chk("t6_rst_valid", 64'(m_valid), 64'd0);
    s_valid = 1'b0;
    tick();
    tick();
    aresetn = 1'b1;
    #1;
    chk("t6_s_ready", 64'(s_ready), 64'd1);
    chk("t6_m_valid", 64'(m_valid), 64'd0);
    chk("t6_drop_count", 64'(drop_count), 64'd0);
    tick();
    drive(8'h1C, 1'b1, 64'h7C); tick();
    chk("t6_new_unit", 64'(m_valid), 64'b1000);
    chk("t6_new_data", m_data[3*DW +: DW], 64'h7C);
    s_valid = 1'b0;
    repeat (2) tick();
    chk("final_drained", 64'(q.size()), 64'd0);
    chk("final_dest_err", 64'(seen_err), 64'(exp_err));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
